// File: rtl/brew_sequencer.sv
// Self-timed drink dispensing sequencer: walks the selected drink's recipe,
// opening one ingredient valve at a time for a fixed number of seconds.
module brew_sequencer #(
    parameter int TICK_DIV   = 100_000_000,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] c_type,
    input  logic       abort,
    output logic [4:0] ingredientes,
    output logic [1:0] step,
    output logic [3:0] secs_left,
    output logic [2:0] c_type_saved,
    output logic       busy,
    output logic       done,
    output logic       aborted
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, DISPENSE, GAP, DONE} state_t;

    state_t        state, state_n;
    logic [PW-1:0] presc, presc_n;
    logic [GW-1:0] gap_cnt, gap_n;
    logic [4:0]    ing_n;
    logic [1:0]    step_n;
    logic [3:0]    secs_n;
    logic [2:0]    ct_n;
    logic          busy_n, done_n, aborted_n;

    // One-hot valve for a given drink and recipe step (bit0 coffee .. bit4 chocolate).
    function automatic logic [4:0] recipe_valve(input logic [2:0] ct, input logic [1:0] idx);
        logic [4:0] v;
        v = 5'b00000;
        case ({ct, idx})
            5'b001_00: v = 5'b00010;
            5'b001_01: v = 5'b00001;
            5'b010_00: v = 5'b00001;
            5'b010_01: v = 5'b00010;
            5'b010_10: v = 5'b00100;
            5'b011_00: v = 5'b00001;
            5'b011_01: v = 5'b00100;
            5'b011_10: v = 5'b01000;
            5'b100_00: v = 5'b00001;
            5'b100_01: v = 5'b10000;
            5'b100_10: v = 5'b00100;
            default:   v = 5'b00000;
        endcase
        return v;
    endfunction

    // Step duration in seconds; only water in coffee and foam in cappuccino run 3 s.
    function automatic logic [3:0] recipe_secs(input logic [2:0] ct, input logic [1:0] idx);
        logic [3:0] s;
        case ({ct, idx})
            5'b001_00, 5'b011_10: s = 4'd3;
            default:              s = 4'd2;
        endcase
        return s;
    endfunction

    // Index of the final step: plain coffee has two steps, the others three.
    function automatic logic [1:0] recipe_last(input logic [2:0] ct);
        return (ct == 3'd1) ? 2'd1 : 2'd2;
    endfunction

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_n   = state;
        presc_n   = presc;
        gap_n     = gap_cnt;
        ing_n     = ingredientes;
        step_n    = step;
        secs_n    = secs_left;
        ct_n      = c_type_saved;
        busy_n    = busy;
        done_n    = 1'b0;
        aborted_n = 1'b0;
        case (state)
            IDLE: begin
                ing_n   = 5'b00000;
                step_n  = 2'd0;
                secs_n  = 4'd0;
                busy_n  = 1'b0;
                presc_n = '0;
                gap_n   = '0;
                if (start && !abort && (c_type >= 3'd1) && (c_type <= 3'd4)) begin
                    state_n = DISPENSE;
                    ct_n    = c_type;
                    busy_n  = 1'b1;
                    ing_n   = recipe_valve(c_type, 2'd0);
                    secs_n  = recipe_secs(c_type, 2'd0);
                end
            end
            DISPENSE: begin
                if (abort) begin
                    state_n   = IDLE;
                    ing_n     = 5'b00000;
                    step_n    = 2'd0;
                    secs_n    = 4'd0;
                    busy_n    = 1'b0;
                    presc_n   = '0;
                    aborted_n = 1'b1;
                end else if (presc == PW'(TICK_DIV - 1)) begin
                    presc_n = '0;
                    if (secs_left == 4'd1) begin
                        ing_n  = 5'b00000;
                        secs_n = 4'd0;
                        gap_n  = '0;
                        if (step == recipe_last(c_type_saved)) begin
                            state_n = DONE;
                            step_n  = 2'd0;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end else begin
                            state_n = GAP;
                        end
                    end else begin
                        secs_n = secs_left - 4'd1;
                    end
                end else begin
                    presc_n = presc + PW'(1);
                end
            end
            GAP: begin
                if (abort) begin
                    state_n   = IDLE;
                    ing_n     = 5'b00000;
                    step_n    = 2'd0;
                    secs_n    = 4'd0;
                    busy_n    = 1'b0;
                    gap_n     = '0;
                    aborted_n = 1'b1;
                end else if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                    state_n = DISPENSE;
                    step_n  = step + 2'd1;
                    ing_n   = recipe_valve(c_type_saved, step + 2'd1);
                    secs_n  = recipe_secs(c_type_saved, step + 2'd1);
                    presc_n = '0;
                    gap_n   = '0;
                end else begin
                    gap_n = gap_cnt + GW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
                ing_n   = 5'b00000;
                step_n  = 2'd0;
                secs_n  = 4'd0;
                busy_n  = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            presc        <= '0;
            gap_cnt      <= '0;
            ingredientes <= 5'b00000;
            step         <= 2'd0;
            secs_left    <= 4'd0;
            c_type_saved <= 3'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            aborted      <= 1'b0;
        end else begin
            state        <= state_n;
            presc        <= presc_n;
            gap_cnt      <= gap_n;
            ingredientes <= ing_n;
            step         <= step_n;
            secs_left    <= secs_n;
            c_type_saved <= ct_n;
            busy         <= busy_n;
            done         <= done_n;
            aborted      <= aborted_n;
        end
    end

endmodule

// File: tb/tb_brew_sequencer.sv
// Testbench for brew_sequencer: directed scenarios plus randomized drinks,
// checked against a recipe-table expansion of the expected cycle trace.
module tb_brew_sequencer;

    localparam int TICK = 4;
    localparam int GAPC = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] c_type;
    logic       abort;
    logic [4:0] ingredientes;
    logic [1:0] step;
    logic [3:0] secs_left;
    logic [2:0] c_type_saved;
    logic       busy, done, aborted;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] ing;
        logic [1:0] stp;
        logic [3:0] secs;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t trace[$];

    // Recipe table: valve bit index and seconds per step, indexed by drink code.
    int rec_bit [0:4][0:2] = '{'{0,0,0}, '{1,0,0}, '{0,1,2}, '{0,2,3}, '{0,4,2}};
    int rec_sec [0:4][0:2] = '{'{0,0,0}, '{3,2,0}, '{2,2,2}, '{2,2,3}, '{2,2,2}};
    int rec_len [0:4]      = '{0, 2, 3, 3, 3};
    int invalid [0:3]      = '{0, 5, 6, 7};

    brew_sequencer #(.TICK_DIV(TICK), .GAP_CYCLES(GAPC)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .c_type       (c_type),
        .abort        (abort),
        .ingredientes (ingredientes),
        .step         (step),
        .secs_left    (secs_left),
        .c_type_saved (c_type_saved),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive inputs, let one rising edge pass, then settle 1 time unit past it.
    task automatic applyStimulus(input logic s, input logic [2:0] ct, input logic ab);
        start  = s;
        c_type = ct;
        abort  = ab;
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_ing"},     ingredientes, 0);
        checkOutput({tag, "_step"},    step, 0);
        checkOutput({tag, "_secs"},    secs_left, 0);
        checkOutput({tag, "_busy"},    busy, 0);
        checkOutput({tag, "_done"},    done, 0);
        checkOutput({tag, "_aborted"}, aborted, 0);
    endtask

    // Expand the recipe table into the expected per-cycle output sequence.
    task automatic buildTrace(input int ct);
        exp_t e;
        trace.delete();
        for (int s = 0; s < rec_len[ct]; s++) begin
            for (int sec = rec_sec[ct][s]; sec >= 1; sec--) begin
                for (int t = 0; t < TICK; t++) begin
                    e.ing = 5'(1 << rec_bit[ct][s]); e.stp = 2'(s); e.secs = 4'(sec);
                    e.busy = 1'b1; e.done = 1'b0;
                    trace.push_back(e);
                end
            end
            if (s < rec_len[ct] - 1) begin
                for (int g = 0; g < GAPC; g++) begin
                    e.ing = 5'b0; e.stp = 2'(s); e.secs = 4'd0; e.busy = 1'b1; e.done = 1'b0;
                    trace.push_back(e);
                end
            end
        end
        e.ing = 5'b0; e.stp = 2'd0; e.secs = 4'd0; e.busy = 1'b0; e.done = 1'b1;
        trace.push_back(e);
    endtask

    // Start a drink and follow it cycle by cycle; abort_at < 0 counts from the end.
    task automatic runDrink(input int ct, input int abort_at, input bit noise);
        int ab_idx;
        buildTrace(ct);
        ab_idx = (abort_at < 0) ? trace.size() + abort_at : abort_at;
        applyStimulus(1'b1, 3'(ct), 1'b0);
        for (int i = 0; i < trace.size(); i++) begin
            checkOutput($sformatf("ct%0d_c%0d_ing", ct, i),  ingredientes, trace[i].ing);
            checkOutput($sformatf("ct%0d_c%0d_secs", ct, i), secs_left, trace[i].secs);
            checkOutput($sformatf("ct%0d_c%0d_busy", ct, i), busy, trace[i].busy);
            checkOutput($sformatf("ct%0d_c%0d_done", ct, i), done, trace[i].done);
            checkOutput($sformatf("ct%0d_c%0d_abrt", ct, i), aborted, 0);
            checkOutput($sformatf("ct%0d_c%0d_saved", ct, i), c_type_saved, ct);
            checkOutput($sformatf("ct%0d_c%0d_onehot", ct, i), $onehot0(ingredientes), 1);
            if (trace[i].busy)
                checkOutput($sformatf("ct%0d_c%0d_step", ct, i), step, trace[i].stp);
            if (i == ab_idx && trace[i].busy) begin
                applyStimulus(1'b0, 3'(ct), 1'b1);
                checkOutput($sformatf("ct%0d_abort_pulse", ct), aborted, 1);
                checkOutput($sformatf("ct%0d_abort_ing", ct), ingredientes, 0);
                checkOutput($sformatf("ct%0d_abort_busy", ct), busy, 0);
                checkOutput($sformatf("ct%0d_abort_done", ct), done, 0);
                checkOutput($sformatf("ct%0d_abort_secs", ct), secs_left, 0);
                return;
            end else if (i == trace.size() - 1) begin
                applyStimulus(1'b0, 3'(ct), noise);
                checkIdle($sformatf("ct%0d_after_done", ct));
            end else if (noise && $urandom_range(0, 3) == 0) begin
                applyStimulus(1'b1, 3'($urandom_range(0, 7)), 1'b0);
            end else begin
                applyStimulus(1'b0, noise ? 3'($urandom_range(0, 7)) : 3'(ct), 1'b0);
            end
        end
    endtask

    // Directed scenarios followed by randomized drinks.
    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        c_type = 3'd0;
        abort  = 1'b0;
        applyStimulus(1'b0, 3'd0, 1'b0);
        applyStimulus(1'b1, 3'd2, 1'b0);
        checkIdle("reset");
        checkOutput("reset_saved", c_type_saved, 0);
        reset = 1'b1;

        applyStimulus(1'b1, 3'd0, 1'b0);
        checkIdle("inv0");
        applyStimulus(1'b1, 3'd6, 1'b0);
        checkIdle("inv6");
        applyStimulus(1'b1, 3'd2, 1'b1);
        checkIdle("start_abort");

        runDrink(1, 1000, 1'b1);
        runDrink(4, 1000, 1'b0);
        runDrink(3, 12, 1'b0);
        runDrink(1, 1000, 1'b0);

        applyStimulus(1'b1, 3'd1, 1'b0);
        applyStimulus(1'b0, 3'd1, 1'b0);
        applyStimulus(1'b0, 3'd1, 1'b0);
        checkOutput("pre_reset_busy", busy, 1);
        reset = 1'b0;
        applyStimulus(1'b0, 3'd1, 1'b0);
        reset = 1'b1;
        checkIdle("mid_reset");
        checkOutput("mid_reset_saved", c_type_saved, 0);
        for (int k = 0; k < 25; k++) begin
            applyStimulus(1'b0, 3'd1, 1'b0);
            checkOutput($sformatf("post_reset_%0d_done", k), done, 0);
            checkOutput($sformatf("post_reset_%0d_abrt", k), aborted, 0);
        end
        runDrink(2, 1000, 1'b0);

        runDrink(3, -2, 1'b0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 3'd3, 1'b0);
            checkIdle($sformatf("late_abort_%0d", k));
        end

        for (int r = 0; r < 24; r++) begin
            int ct;
            int mode;
            ct   = $urandom_range(1, 4);
            mode = $urandom_range(0, 2);
            runDrink(ct, (mode == 1) ? $urandom_range(0, 20) : 1000, mode == 2);
            repeat ($urandom_range(0, 3)) begin
                applyStimulus(1'($urandom_range(0, 1)), 3'(invalid[$urandom_range(0, 3)]),
                              1'($urandom_range(0, 1)));
                checkIdle($sformatf("rand_idle_%0d", r));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
